// File: rtl/spi_slave_regs_if.sv
// Pin-level bundle between an SPI master and spi_slave_regs, plus the
// slave's register-write notification outputs.
interface spi_slave_regs_if;
  // cs/sck/mosi are asynchronous pins. wr_valid and frame_done are one-cycle
  // strobes with no ready/back-pressure: wr_addr/wr_data are valid while wr_valid
  // is high and then hold until the next write.
  logic        cs;
  logic        sck;
  logic        mosi;
  logic        miso;
  logic        wr_valid;
  logic [23:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        frame_done;

  modport master (
    output cs, sck, mosi,
    input  miso, wr_valid, wr_addr, wr_data, busy, frame_done
  );

  modport slave (
    input  cs, sck, mosi,
    output miso, wr_valid, wr_addr, wr_data, busy, frame_done
  );
endinterface

// File: rtl/spi_slave_regs.sv
// Oversampled SPI mode-3 slave with a 32-bit register bank (64-bit frames).
// Optional SPI_SLAVE_STATUS_EN adds a frame counter readable at 24'hFF_FFFF.
module spi_slave_regs #(
  parameter int DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  spi_slave_regs_if.slave   bus,
  output logic [2:0]        o_dbg_state
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMD  = 3'd1,
    S_ADDR = 3'd2,
    S_DATA = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t      r_state;
  logic        r_cs_s1, r_cs_s2, r_cs_s3;
  logic        r_sck_s1, r_sck_s2, r_sck_s3;
  logic        r_mosi_s1, r_mosi_s2;
  logic [5:0]  r_bit_cnt;
  logic [7:0]  r_cmd;
  logic [23:0] r_addr;
  logic [31:0] r_data;
  logic [31:0] r_tx;
  logic        r_rd_pend;
  logic        r_miso;
  logic        r_wr_valid;
  logic        r_frame_done;
  logic [23:0] r_wr_addr;
  logic [31:0] r_wr_data;
  logic [31:0] r_bank [DEPTH];
`ifdef SPI_SLAVE_STATUS_EN
  logic [15:0] r_frame_cnt;
`endif

  logic        w_rise, w_fall, w_cs_fall, w_addr_ok;
  logic [31:0] w_data_next;
  logic [31:0] w_rd_word;

  assign w_rise      = r_sck_s2 & ~r_sck_s3;
  assign w_fall      = ~r_sck_s2 & r_sck_s3;
  assign w_cs_fall   = ~r_cs_s2 & r_cs_s3;
  assign w_addr_ok   = (r_addr < 24'(DEPTH));
  assign w_data_next = {r_data[30:0], r_mosi_s2};

  always_comb begin
    w_rd_word = 32'h0000_0000;
    if (w_addr_ok) w_rd_word = r_bank[r_addr[AW-1:0]];
`ifdef SPI_SLAVE_STATUS_EN
    else if (r_addr == 24'hFF_FFFF) w_rd_word = {16'h0000, r_frame_cnt};
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cs_s1      <= 1'b0;
      r_cs_s2      <= 1'b0;
      r_cs_s3      <= 1'b0;
      r_sck_s1     <= 1'b0;
      r_sck_s2     <= 1'b0;
      r_sck_s3     <= 1'b0;
      r_mosi_s1    <= 1'b0;
      r_mosi_s2    <= 1'b0;
      r_bit_cnt    <= 6'd0;
      r_cmd        <= 8'h00;
      r_addr       <= 24'h0;
      r_data       <= 32'h0;
      r_tx         <= 32'h0;
      r_rd_pend    <= 1'b0;
      r_miso       <= 1'b0;
      r_wr_valid   <= 1'b0;
      r_frame_done <= 1'b0;
      r_wr_addr    <= 24'h0;
      r_wr_data    <= 32'h0;
      for (int i = 0; i < DEPTH; i++) r_bank[i] <= 32'h0;
`ifdef SPI_SLAVE_STATUS_EN
      r_frame_cnt  <= 16'h0;
`endif
    end else begin
      r_cs_s1   <= bus.cs;
      r_cs_s2   <= r_cs_s1;
      r_cs_s3   <= r_cs_s2;
      r_sck_s1  <= bus.sck;
      r_sck_s2  <= r_sck_s1;
      r_sck_s3  <= r_sck_s2;
      r_mosi_s1 <= bus.mosi;
      r_mosi_s2 <= r_mosi_s1;

      r_wr_valid   <= 1'b0;
      r_frame_done <= 1'b0;
      r_rd_pend    <= 1'b0;
      // Address is complete only one cycle after the 32nd rise, so fetch then.
      if (r_rd_pend) r_tx <= w_rd_word;

      if (r_cs_s2) begin
        r_state   <= S_IDLE;
        r_bit_cnt <= 6'd0;
        r_cmd     <= 8'h00;
        r_addr    <= 24'h0;
        r_data    <= 32'h0;
        r_tx      <= 32'h0;
        r_miso    <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: if (w_cs_fall) r_state <= S_CMD;
          S_CMD: if (w_rise) begin
            r_cmd     <= {r_cmd[6:0], r_mosi_s2};
            r_bit_cnt <= r_bit_cnt + 6'd1;
            if (r_bit_cnt == 6'd7) r_state <= S_ADDR;
          end
          S_ADDR: if (w_rise) begin
            r_addr    <= {r_addr[22:0], r_mosi_s2};
            r_bit_cnt <= r_bit_cnt + 6'd1;
            if (r_bit_cnt == 6'd31) begin
              r_state   <= S_DATA;
              r_rd_pend <= (r_cmd != 8'h00);
            end
          end
          S_DATA: begin
            if (w_rise) begin
              r_data    <= w_data_next;
              r_bit_cnt <= r_bit_cnt + 6'd1;
              if (r_bit_cnt == 6'd63) begin
                r_state      <= S_DONE;
                r_frame_done <= 1'b1;
`ifdef SPI_SLAVE_STATUS_EN
                r_frame_cnt  <= r_frame_cnt + 16'd1;
`endif
                if (r_cmd == 8'h00 && w_addr_ok) begin
                  r_bank[r_addr[AW-1:0]] <= w_data_next;
                  r_wr_valid <= 1'b1;
                  r_wr_addr  <= r_addr;
                  r_wr_data  <= w_data_next;
                end
              end
            end else if (w_fall) begin
              r_miso <= r_tx[31];
              r_tx   <= {r_tx[30:0], 1'b0};
            end
          end
          S_DONE: ;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.miso       = r_miso;
  assign bus.wr_valid   = r_wr_valid;
  assign bus.wr_addr    = r_wr_addr;
  assign bus.wr_data    = r_wr_data;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.frame_done = r_frame_done;
  assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_spi_slave_regs.sv
// Randomised bench for spi_slave_regs: SPI mode-3 driver, register-bank model,
// scoreboard queues checked by monitors on wr_valid and frame_done.
module tb_spi_slave_regs;
  localparam int DEPTH = 16;
  localparam int HALF  = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] dbg_state;
  int         checks = 0;
  int         errors = 0;

  spi_slave_regs_if bus();

  spi_slave_regs #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Reference model and scoreboard queues
  logic [31:0] mdl_mem [DEPTH];
  int          mdl_frames = 0;
  logic [55:0] exp_wr_q [$];
  logic [32:0] exp_fr_q [$];

  int          mon_cnt = 0;
  logic [31:0] mon_rx  = 32'h0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [23:0] addr);
    if (addr < DEPTH) return mdl_mem[addr];
`ifdef SPI_SLAVE_STATUS_EN
    if (addr == 24'hFF_FFFF) return {16'h0000, mdl_frames[15:0]};
`endif
    return 32'h0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 32'h0;
    mdl_frames = 0;
  endtask

  // Master-side capture of the read word (master samples on SCK rise)
  always @(posedge bus.sck or posedge bus.cs) begin
    if (bus.cs) mon_cnt <= 0;
    else begin
      if (mon_cnt >= 32 && mon_cnt < 64) mon_rx <= {mon_rx[30:0], bus.miso};
      mon_cnt <= mon_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (!rst && bus.wr_valid) begin
      if (exp_wr_q.size() == 0) check("wr_valid_unexpected", 64'd1, 64'd0);
      else begin
        check("wr_addr", {40'h0, bus.wr_addr}, {40'h0, exp_wr_q[0][55:32]});
        check("wr_data", {32'h0, bus.wr_data}, {32'h0, exp_wr_q[0][31:0]});
        void'(exp_wr_q.pop_front());
      end
    end
    if (!rst && bus.frame_done) begin
      if (exp_fr_q.size() == 0) check("frame_done_unexpected", 64'd1, 64'd0);
      else begin
        if (exp_fr_q[0][32]) check("rd_data", {32'h0, mon_rx}, {32'h0, exp_fr_q[0][31:0]});
        void'(exp_fr_q.pop_front());
      end
    end
  end

  task automatic spi_frame(input logic [7:0] cmd, input logic [23:0] addr,
                           input logic [31:0] data, input int nclk,
                           input int abort_at, input int rst_at);
    logic [63:0] frame;
    bit aborted;
    frame   = {cmd, addr, data};
    aborted = 1'b0;
    if (abort_at < 0 && rst_at < 0 && nclk >= 64) begin
      if (cmd == 8'h00) begin
        if (addr < DEPTH) begin
          exp_wr_q.push_back({addr, data});
          mdl_mem[addr] = data;
        end
        exp_fr_q.push_back({1'b0, 32'h0});
      end else begin
        exp_fr_q.push_back({1'b1, model_read(addr)});
      end
      mdl_frames++;
    end
    @(posedge clk); #1 bus.cs = 1'b0;
    repeat (HALF) @(posedge clk);
    for (int i = 0; i < nclk; i++) begin
      if (i == abort_at) begin
        @(negedge clk) check("busy_in_frame", {63'h0, bus.busy}, 64'd1);
        aborted = 1'b1;
        break;
      end
      if (i == rst_at) begin
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mid_miso", {63'h0, bus.miso}, 64'd0);
        check("rst_mid_busy", {63'h0, bus.busy}, 64'd0);
        model_reset();
      end
      @(posedge clk); #1 bus.sck = 1'b0;
      bus.mosi = (i < 64) ? frame[63-i] : 1'b0;
      repeat (HALF - 1) @(posedge clk);
      #1 bus.sck = 1'b1;
      repeat (HALF - 1) @(posedge clk);
    end
    repeat (HALF) @(posedge clk);
    #1 bus.cs = 1'b1;
    if (aborted) begin
      repeat (3) @(posedge clk);
      @(negedge clk) check("busy_after_abort", {63'h0, bus.busy}, 64'd0);
    end
    repeat (10) @(posedge clk);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  cmd;
    logic [23:0] addr;
    model_reset();
    bus.cs = 1'b1; bus.sck = 1'b1; bus.mosi = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_miso",       {63'h0, bus.miso},       64'd0);
    check("rst_wr_valid",   {63'h0, bus.wr_valid},   64'd0);
    check("rst_wr_addr",    {40'h0, bus.wr_addr},    64'd0);
    check("rst_wr_data",    {32'h0, bus.wr_data},    64'd0);
    check("rst_busy",       {63'h0, bus.busy},       64'd0);
    check("rst_frame_done", {63'h0, bus.frame_done}, 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (5) @(posedge clk);

    spi_frame(8'h00, 24'd3,  32'hDEAD_BEEF, 64, -1, -1);
    spi_frame(8'h01, 24'd3,  32'h0,         64, -1, -1);
    spi_frame(8'h00, 24'd16, 32'h1234_5678, 64, -1, -1);
    spi_frame(8'h01, 24'd16, 32'h0,         64, -1, -1);
    spi_frame(8'h7F, 24'd3,  32'h0,         64, -1, -1);
    spi_frame(8'h00, 24'd5,  32'hAAAA_5555, 64, 20, -1);
    spi_frame(8'h00, 24'd5,  32'h0BAD_F00D, 64, -1, -1);
    spi_frame(8'h01, 24'd5,  32'h0,         64, -1, -1);
    spi_frame(8'h01, 24'd3,  32'h0,         64, -1, 40);
    spi_frame(8'h01, 24'd0,  32'h0,         64, -1, -1);
    spi_frame(8'h01, 24'd3,  32'h0,         64, -1, -1);
    spi_frame(8'h00, 24'd7,  32'h1357_9BDF, 70, -1, -1);
    spi_frame(8'h01, 24'd7,  32'h0,         64, -1, -1);
    spi_frame(8'h00, 24'hFF_FFFF, 32'hFFFF_0000, 64, -1, -1);
    spi_frame(8'h01, 24'hFF_FFFF, 32'h0,    64, -1, -1);

    for (int n = 0; n < 36; n++) begin
      cmd = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      case ($urandom_range(0, 9))
        0:       addr = 24'($urandom_range(16, 40));
        1:       addr = 24'hFF_FFFF;
        default: addr = 24'($urandom_range(0, DEPTH - 1));
      endcase
      spi_frame(cmd, addr, $urandom, (n % 7 == 3) ? 67 : 64, -1, -1);
    end

    repeat (20) @(posedge clk);
    check("wr_queue_drained",    64'(exp_wr_q.size()), 64'd0);
    check("frame_queue_drained", 64'(exp_fr_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
